// File: rtl/system_command_decoder.sv
`default_nettype none
// ============================================================================
// Module  : system_command_decoder
// Brief   : Byte-stream command decoder driving register-file and ALU strobes.
// Revision: 1.0
// ============================================================================
module system_command_decoder #(
    parameter int BUS_WIDTH      = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int FUN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_data_valid,
    input  logic [BUS_WIDTH-1:0]  rx_data,
    output logic                  reg_write_enable,
    output logic                  reg_read_enable,
    output logic [ADDR_WIDTH-1:0] reg_address,
    output logic [BUS_WIDTH-1:0]  reg_write_data,
    output logic                  alu_enable,
    output logic [FUN_WIDTH-1:0]  alu_function,
    output logic                  busy,
    output logic                  cmd_error
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CMD_WRITE  = 8'hAA;
    localparam logic [7:0] CMD_READ   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP = 8'hCC;
    localparam logic [7:0] CMD_ALU    = 8'hDD;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_DATA = 3'd2,
        S_RD_ADDR = 3'd3,
        S_OP_A    = 3'd4,
        S_OP_B    = 3'd5,
        S_ALU_FUN = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_lat_q, addr_lat_d;
    logic                  we_q, we_d;
    logic                  re_q, re_d;
    logic                  alu_en_q, alu_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_WIDTH-1:0]  wdata_q, wdata_d;
    logic [FUN_WIDTH-1:0]  fun_q, fun_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_lat_q <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            alu_en_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            fun_q      <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_lat_q <= addr_lat_d;
            we_q       <= we_d;
            re_q       <= re_d;
            alu_en_q   <= alu_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            fun_q      <= fun_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_lat_d = addr_lat_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        alu_en_d   = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        fun_d      = fun_q;
        err_d      = 1'b0;

        if (state_q == S_IDLE) begin
            cnt_d = '0;
            if (rx_data_valid) begin
                case (rx_data[7:0])
                    CMD_WRITE:  state_d = S_WR_ADDR;
                    CMD_READ:   state_d = S_RD_ADDR;
                    CMD_ALU_OP: state_d = S_OP_A;
                    CMD_ALU:    state_d = S_ALU_FUN;
                    default:    err_d   = 1'b1;
                endcase
            end
        end else if (rx_data_valid) begin
            // An accepted byte always wins over a timeout in the same cycle.
            cnt_d = '0;
            case (state_q)
                S_WR_ADDR: begin
                    addr_lat_d = rx_data[ADDR_WIDTH-1:0];
                    state_d    = S_WR_DATA;
                end
                S_WR_DATA: begin
                    we_d    = 1'b1;
                    addr_d  = addr_lat_q;
                    wdata_d = rx_data;
                    state_d = S_IDLE;
                end
                S_RD_ADDR: begin
                    re_d    = 1'b1;
                    addr_d  = rx_data[ADDR_WIDTH-1:0];
                    state_d = S_IDLE;
                end
                S_OP_A: begin
                    we_d    = 1'b1;
                    addr_d  = '0;
                    wdata_d = rx_data;
                    state_d = S_OP_B;
                end
                S_OP_B: begin
                    we_d    = 1'b1;
                    addr_d  = ADDR_WIDTH'(1);
                    wdata_d = rx_data;
                    state_d = S_ALU_FUN;
                end
                S_ALU_FUN: begin
                    alu_en_d = 1'b1;
                    fun_d    = rx_data[FUN_WIDTH-1:0];
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (cnt_q == CNT_MAX) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign reg_write_enable = we_q;
    assign reg_read_enable  = re_q;
    assign reg_address      = addr_q;
    assign reg_write_data   = wdata_q;
    assign alu_enable       = alu_en_q;
    assign alu_function     = fun_q;
    assign busy             = busy_q;
    assign cmd_error        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_system_command_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_system_command_decoder
// Brief   : Directed self-checking bench for system_command_decoder.
// Revision: 1.0
// ============================================================================
module tb_system_command_decoder;

    localparam int BW = 8;
    localparam int AW = 4;
    localparam int FW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx_data_valid = 1'b0;
    logic [BW-1:0] rx_data = '0;
    logic          reg_write_enable;
    logic          reg_read_enable;
    logic [AW-1:0] reg_address;
    logic [BW-1:0] reg_write_data;
    logic          alu_enable;
    logic [FW-1:0] alu_function;
    logic          busy;
    logic          cmd_error;

    int n_checks = 0;
    int n_fail   = 0;

    system_command_decoder #(
        .BUS_WIDTH      (BW),
        .ADDR_WIDTH     (AW),
        .FUN_WIDTH      (FW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_data_valid    (rx_data_valid),
        .rx_data          (rx_data),
        .reg_write_enable (reg_write_enable),
        .reg_read_enable  (reg_read_enable),
        .reg_address      (reg_address),
        .reg_write_data   (reg_write_data),
        .alu_enable       (alu_enable),
        .alu_function     (alu_function),
        .busy             (busy),
        .cmd_error        (cmd_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one input cycle, then look at the registered result 1 ns after the edge.
    task automatic drive(input logic v, input logic [BW-1:0] d);
        rx_data_valid = v;
        rx_data       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_strobes(input string tag, input logic we, input logic re,
                               input logic ae, input logic er, input logic bz);
        chk({tag, ".we"},   32'(reg_write_enable), 32'(we));
        chk({tag, ".re"},   32'(reg_read_enable),  32'(re));
        chk({tag, ".alu"},  32'(alu_enable),       32'(ae));
        chk({tag, ".err"},  32'(cmd_error),        32'(er));
        chk({tag, ".busy"}, 32'(busy),             32'(bz));
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_strobes("rst", 0, 0, 0, 0, 0);
        chk("rst.addr",  32'(reg_address),    32'h0);
        chk("rst.wdata", 32'(reg_write_data), 32'h0);
        chk("rst.fun",   32'(alu_function),   32'h0);
        reset = 1'b1;

        // Write frame AA,05,3C
        drive(1, 8'hAA); chk_strobes("wr.cmd", 0, 0, 0, 0, 1);
        drive(1, 8'h05); chk_strobes("wr.addr", 0, 0, 0, 0, 1);
        drive(1, 8'h3C); chk_strobes("wr.data", 1, 0, 0, 0, 0);
        chk("wr.addr_out", 32'(reg_address),    32'h5);
        chk("wr.wdata",    32'(reg_write_data), 32'h3C);
        drive(0, 8'h00); chk_strobes("wr.after", 0, 0, 0, 0, 0);
        chk("wr.addr_hold",  32'(reg_address),    32'h5);
        chk("wr.wdata_hold", 32'(reg_write_data), 32'h3C);

        // Back-to-back ALU with operands CC,12,34,02
        drive(1, 8'hCC); chk_strobes("alu.cmd", 0, 0, 0, 0, 1);
        drive(1, 8'h12); chk_strobes("alu.opa", 1, 0, 0, 0, 1);
        chk("alu.opa_addr", 32'(reg_address),    32'h0);
        chk("alu.opa_data", 32'(reg_write_data), 32'h12);
        drive(1, 8'h34); chk_strobes("alu.opb", 1, 0, 0, 0, 1);
        chk("alu.opb_addr", 32'(reg_address),    32'h1);
        chk("alu.opb_data", 32'(reg_write_data), 32'h34);
        drive(1, 8'h02); chk_strobes("alu.fun", 0, 0, 1, 0, 0);
        chk("alu.fun_val",   32'(alu_function), 32'h2);
        chk("alu.addr_hold", 32'(reg_address),  32'h1);
        drive(0, 8'h00); chk_strobes("alu.after", 0, 0, 0, 0, 0);
        chk("alu.fun_hold", 32'(alu_function), 32'h2);

        // ALU without operands, immediately followed by a read
        drive(1, 8'hDD); chk_strobes("dd.cmd", 0, 0, 0, 0, 1);
        drive(1, 8'h19); chk_strobes("dd.fun", 0, 0, 1, 0, 0);
        chk("dd.fun_val", 32'(alu_function), 32'h9);

        // Read frame BB,0A then illegal 7F
        drive(1, 8'hBB); chk_strobes("rd.cmd", 0, 0, 0, 0, 1);
        drive(1, 8'h0A); chk_strobes("rd.addr", 0, 1, 0, 0, 0);
        chk("rd.addr_out", 32'(reg_address), 32'hA);
        drive(1, 8'h7F); chk_strobes("ill.byte", 0, 0, 0, 1, 0);
        chk("ill.addr_hold", 32'(reg_address), 32'hA);
        drive(0, 8'h00); chk_strobes("ill.after", 0, 0, 0, 0, 0);

        // Timeout: AA,03 then silence
        drive(1, 8'hAA);
        drive(1, 8'h03); chk_strobes("to.start", 0, 0, 0, 0, 1);
        for (int i = 0; i < TO - 1; i++) begin
            drive(0, 8'h00);
            chk_strobes($sformatf("to.wait%0d", i), 0, 0, 0, 0, 1);
        end
        drive(0, 8'h00); chk_strobes("to.fire", 0, 0, 0, 1, 0);
        drive(0, 8'h00); chk_strobes("to.after", 0, 0, 0, 0, 0);
        chk("to.addr_hold", 32'(reg_address), 32'hA);

        // Byte arriving exactly in the threshold cycle is accepted
        drive(1, 8'hAA);
        drive(1, 8'h03);
        for (int i = 0; i < TO - 1; i++) drive(0, 8'h00);
        chk_strobes("th.pre", 0, 0, 0, 0, 1);
        drive(1, 8'h44); chk_strobes("th.accept", 1, 0, 0, 0, 0);
        chk("th.addr",  32'(reg_address),    32'h3);
        chk("th.wdata", 32'(reg_write_data), 32'h44);

        // Reset mid-frame after CC,11
        drive(1, 8'hCC);
        drive(1, 8'h11); chk_strobes("mr.opa", 1, 0, 0, 0, 1);
        rx_data_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_strobes("mr.async", 0, 0, 0, 0, 0);
        chk("mr.addr",  32'(reg_address),    32'h0);
        chk("mr.wdata", 32'(reg_write_data), 32'h0);
        chk("mr.fun",   32'(alu_function),   32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1, 8'hBB); chk_strobes("mr.cmd", 0, 0, 0, 0, 1);
        drive(1, 8'h02); chk_strobes("mr.read", 0, 1, 0, 0, 0);
        chk("mr.read_addr", 32'(reg_address), 32'h2);
        drive(0, 8'h00); chk_strobes("mr.after", 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/system_command_decoder.md
SYSTEM_COMMAND_DECODER -- requirements
Module: system_command_decoder

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, byte width of incoming command and data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register-file address width.
REQ-003 SHALL have parameter FUN_WIDTH, default 4, ALU function code width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, idle cycles allowed mid-frame before abort; legal values are 2 or more.
REQ-005 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rx_data_valid, input, 1, single-cycle byte strobe from the upstream data synchronizer.
REQ-008 SHALL have port rx_data, input, BUS_WIDTH, received byte; meaningful only while rx_data_valid=1.
REQ-009 SHALL have port reg_write_enable, output, 1, one-cycle register-file write strobe.
REQ-010 SHALL have port reg_read_enable, output, 1, one-cycle register-file read strobe.
REQ-011 SHALL have port reg_address, output, ADDR_WIDTH, register-file address.
REQ-012 SHALL have port reg_write_data, output, BUS_WIDTH, register-file write data.
REQ-013 SHALL have port alu_enable, output, 1, one-cycle ALU start strobe.
REQ-014 SHALL have port alu_function, output, FUN_WIDTH, ALU operation code.
REQ-015 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-016 SHALL have port cmd_error, output, 1, one-cycle pulse on an illegal command or a timeout.

Function
REQ-017 SHALL decode these command bytes (low 8 bits compared):
- 0xAA: write (addr, data).
- 0xBB: read (addr).
- 0xCC: ALU with operands (A, B, fun).
- 0xDD: ALU, no operands (fun).
REQ-018 SHALL implement states IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B and ALU_FUN; states change only on cycles with rx_data_valid=1, except on timeout.
REQ-019 In IDLE, the FSM SHALL go AA->WR_ADDR, BB->RD_ADDR, CC->OP_A and DD->ALU_FUN; any other byte keeps IDLE and pulses cmd_error on the next cycle.
REQ-020 In WR_ADDR, the FSM SHALL latch rx_data[ADDR_WIDTH-1:0] into an internal address register and go to WR_DATA.
REQ-021 In WR_DATA, the block SHALL drive reg_write_enable=1, reg_address=latched address and reg_write_data=byte on the next cycle, then go to IDLE.
REQ-022 In RD_ADDR, the block SHALL drive reg_read_enable=1 and reg_address=byte[ADDR_WIDTH-1:0] on the next cycle, then go to IDLE.
REQ-023 In OP_A and OP_B, the block SHALL issue a write strobe with the byte to address 0 (OP_A->OP_B) and address 1 (OP_B->ALU_FUN) respectively.
REQ-024 In ALU_FUN, the block SHALL drive alu_enable=1 and alu_function=byte[FUN_WIDTH-1:0] on the next cycle, then go to IDLE.
REQ-025 Every strobe SHALL assert exactly 1 cycle after the accepting rx_data_valid cycle and last exactly 1 cycle; all outputs registered, with no input-to-output combinational path.
REQ-026 reg_address, reg_write_data and alu_function SHALL change only together with their strobe and hold their value otherwise.
REQ-027 At most one of reg_write_enable, reg_read_enable and alu_enable SHALL be high in any cycle.
REQ-028 busy SHALL be 1 exactly when the state is not IDLE.
REQ-029 The timeout counter SHALL:
- clear in IDLE and on every accepted byte;
- increment on each non-IDLE cycle without rx_data_valid.
REQ-030 When the counter equals TIMEOUT_CYCLES-1 and rx_data_valid=0, the FSM SHALL go to IDLE, clear the counter, pulse cmd_error on the next cycle and issue no strobe.
REQ-031 If rx_data_valid=1 in the threshold cycle, the block SHALL accept the byte normally with no timeout.
REQ-032 Bytes on consecutive cycles SHALL each be accepted with none dropped; a new command byte is legal in the same cycle as the previous frame's final strobe.
REQ-033 An aborted frame SHALL NOT roll back operand writes already issued.

Reset
REQ-034 While reset=0, asynchronously: state=IDLE, counter=0, and all outputs (strobes, reg_address, reg_write_data, alu_function, busy, cmd_error) SHALL be 0.
REQ-035 Reset mid-frame SHALL discard the partial frame; after release, the first accepted byte SHALL be decoded as a command.
REQ-036 After reset release, operation SHALL resume on the first rising clk edge.

Verification
REQ-037 Bench SHALL cover: bytes AA,05,3C -> 1 cycle after 3C: reg_write_enable=1, reg_address=5, reg_write_data=0x3C; busy=0 afterwards.
REQ-038 Bench SHALL cover: back-to-back CC,12,34,02 -> write addr0=0x12, write addr1=0x34, then alu_enable with alu_function=2; each strobe 1 cycle after its byte.
REQ-039 Bench SHALL cover: BB,0A,7F -> reg_read_enable with reg_address=0xA; then 7F -> cmd_error pulse, state stays IDLE, no strobe.
REQ-040 Bench SHALL cover: AA,03 then silence -> cmd_error after TIMEOUT_CYCLES-1 idle cycles, busy=0, no write; a byte arriving exactly in the threshold cycle is instead accepted.
REQ-041 Bench SHALL cover: reset asserted after CC,11 -> outputs 0 immediately; after release, BB,02 -> read strobe at address 2 and no address-1 write.
